// File: rtl/addsub_pkg.sv
// Shared constants, mode encoding and saturation helper for the pipelined add/subtract unit.
// Optional build macro: ADDSUB_SAT_EN (clamp on signed overflow).
package addsub_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   localparam int FLG_CARRY = 0;
   localparam int FLG_OVF   = 1;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_NEG   = 3;
   localparam int FLG_W     = 4;

   localparam int SAT_MAX_W = 64;

   // sign=0 -> signed max (0111..1), sign=1 -> signed min (1000..0); callers cast to their width.
   function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic sign);
      logic [SAT_MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < SAT_MAX_W; i++) begin
         if (i < width - 1) begin
            v[i] = ~sign;
         end else if (i == width - 1) begin
            v[i] = sign;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/result handshake bundle for addsub_pipe; the producer/consumer side uses master.
interface addsub_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic             mode;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             carry;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, mode, in1, in2, out_ready,
      input  in_ready, out_valid, out, carry, ovf, zero, neg
   );

   modport slave (
      input  in_valid, mode, in1, in2, out_ready,
      output in_ready, out_valid, out, carry, ovf, zero, neg
   );
endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract with carry/borrow, overflow, zero and negative flags.
// Optional build macro: ADDSUB_SAT_EN clamps the result to signed max/min on overflow.
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] res,
   output logic [FLG_W-1:0] flags
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic             ovf;

   always_comb begin
      b_eff = (mode == MODE_SUB) ? ~in2 : in2;
      // Subtraction is IN1 + ~IN2 + 1; the mode bit doubles as the carry-in.
      sum   = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};
      ovf   = (in1[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != in1[WIDTH-1]);
      res   = sum[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
      if (ovf) begin
         res = WIDTH'(sat_value(WIDTH, in1[WIDTH-1]));
      end
`endif
      flags            = '0;
      flags[FLG_CARRY] = (mode == MODE_SUB) ? ~sum[WIDTH] : sum[WIDTH];
      flags[FLG_OVF]   = ovf;
      flags[FLG_ZERO]  = (res == '0);
      flags[FLG_NEG]   = res[WIDTH-1];
   end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: one addsub_core feeding a STAGES-deep elastic slot chain.
// Optional build macro: ADDSUB_SAT_EN (saturating result, handled inside addsub_core).
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input logic      clk,
   input logic      rst_n,
   addsub_if.slave  bus
);

   logic [WIDTH-1:0] core_res;
   logic [FLG_W-1:0] core_flg;

   logic [STAGES:0]   load;
   logic [STAGES-1:0] slot_valid;
   logic [WIDTH-1:0]  slot_res [STAGES];
   logic [FLG_W-1:0]  slot_flg [STAGES];

   addsub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .mode  (bus.mode),
      .in1   (bus.in1),
      .in2   (bus.in2),
      .res   (core_res),
      .flags (core_flg)
   );

   // A slot may load when it is empty or its occupant moves on; load[STAGES] is the consumer.
   always_comb begin
      load         = '0;
      load[STAGES] = bus.out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         load[i] = ~slot_valid[i] | load[i+1];
      end
   end

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_slot
         logic             src_valid;
         logic [WIDTH-1:0] src_res;
         logic [FLG_W-1:0] src_flg;
         logic             valid_reg;
         logic [WIDTH-1:0] res_reg;
         logic [FLG_W-1:0] flg_reg;

         if (gi == 0) begin : g_head
            assign src_valid = bus.in_valid;
            assign src_res   = core_res;
            assign src_flg   = core_flg;
         end else begin : g_link
            assign src_valid = slot_valid[gi-1];
            assign src_res   = slot_res[gi-1];
            assign src_flg   = slot_flg[gi-1];
         end

         // Payload only updates on a real transfer so an idle output keeps its last value.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               res_reg   <= '0;
               flg_reg   <= '0;
            end else if (load[gi]) begin
               valid_reg <= src_valid;
               if (src_valid) begin
                  res_reg <= src_res;
                  flg_reg <= src_flg;
               end
            end
         end

         assign slot_valid[gi] = valid_reg;
         assign slot_res[gi]   = res_reg;
         assign slot_flg[gi]   = flg_reg;
      end
   endgenerate

   assign bus.in_ready  = load[0];
   assign bus.out_valid = slot_valid[STAGES-1];
   assign bus.out       = slot_res[STAGES-1];
   assign bus.carry     = slot_flg[STAGES-1][FLG_CARRY];
   assign bus.ovf       = slot_flg[STAGES-1][FLG_OVF];
   assign bus.zero      = slot_flg[STAGES-1][FLG_ZERO];
   assign bus.neg       = slot_flg[STAGES-1][FLG_NEG];

endmodule
